// File: rtl/scr1_vmem_responder.sv
// rtl/scr1_vmem_responder.sv - SCR1 vector-memory target endpoint; sub-word access enabled by SCR1_VMEM_SUBWORD_EN
package scr1_vmem_pkg;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int LANE             = 4;

    typedef logic [LANE-1:0][31:0] type_vector;

    typedef enum logic [1:0] {
        SCR1_MEM_CMD_RD    = 2'b00,
        SCR1_MEM_CMD_WR    = 2'b01,
        SCR1_MEM_CMD_ERROR = 2'b11
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_IDLE   = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_vmem_responder
    import scr1_vmem_pkg::*;
#(
    parameter int                          SCR1_VMEM_DEPTH       = 256,
    parameter int                          SCR1_VMEM_WAIT_STATES = 0,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_VMEM_BASE_ADDR   = SCR1_DMEM_AWIDTH'('h00010000)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic                        port_req_ack,
    input  logic                        port_req,
    input  type_scr1_mem_cmd_e          port_cmd,
    input  type_scr1_mem_width_e        port_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] port_addr,
    input  type_vector                  port_wdata,
    output type_vector                  port_rdata,
    output type_scr1_mem_resp_e         port_resp
);

    localparam int IDX_W  = $clog2(SCR1_VMEM_DEPTH);
    localparam int LANE_W = $clog2(LANE);
    localparam int VB_W   = LANE_W + 2;
    localparam logic [SCR1_DMEM_AWIDTH-1:0] SPAN = SCR1_DMEM_AWIDTH'(SCR1_VMEM_DEPTH * LANE * 4);
    localparam logic [3:0] WS = 4'(SCR1_VMEM_WAIT_STATES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Everything the memory needs at commit time, decoded once at acceptance
    typedef struct packed {
        logic                 wr;
        logic                 err;
`ifdef SCR1_VMEM_SUBWORD_EN
        logic                 full;
        logic [LANE_W-1:0]    lane;
        logic [3:0]           bmask;
`endif
        logic [IDX_W-1:0]     entry;
        type_vector           wdata;
    } op_t;

    logic [1:0]                  state;
    logic [3:0]                  cnt;
    logic                        accept;
    logic                        act_en;
    op_t                         live_op;
    op_t                         act_op;
    logic [SCR1_DMEM_AWIDTH-1:0] off;
    logic                        in_range;
    logic                        vec_aligned;
    logic                        cmd_ok;
    logic                        legal;
    type_vector                  mem [SCR1_VMEM_DEPTH];

    assign port_req_ack = rst_n && ((state == ST_IDLE) || (state == ST_RESP));
    assign accept       = port_req && port_req_ack;

    // Decode the request on the bus into a commit-ready operation
    always_comb begin
        off         = port_addr - SCR1_VMEM_BASE_ADDR;
        in_range    = (off < SPAN);
        vec_aligned = (off[VB_W-1:0] == '0);
        cmd_ok      = (port_cmd == SCR1_MEM_CMD_RD) || (port_cmd == SCR1_MEM_CMD_WR);
        legal       = 1'b0;
        live_op       = '0;
        live_op.wr    = (port_cmd == SCR1_MEM_CMD_WR);
        live_op.entry = off[VB_W +: IDX_W];
        live_op.wdata = port_wdata;
`ifdef SCR1_VMEM_SUBWORD_EN
        live_op.full  = (port_width == SCR1_MEM_WIDTH_WORD) && vec_aligned;
        live_op.lane  = off[2 +: LANE_W];
        case (port_width)
            SCR1_MEM_WIDTH_BYTE: begin
                legal         = 1'b1;
                live_op.bmask = 4'b0001 << off[1:0];
            end
            SCR1_MEM_WIDTH_HWORD: begin
                legal         = ~off[0];
                live_op.bmask = off[1] ? 4'b1100 : 4'b0011;
            end
            SCR1_MEM_WIDTH_WORD: begin
                legal         = (off[1:0] == 2'b00);
                live_op.bmask = 4'b1111;
            end
            default: begin
                legal         = 1'b0;
                live_op.bmask = 4'b0000;
            end
        endcase
`else
        legal = (port_width == SCR1_MEM_WIDTH_WORD) && vec_aligned;
`endif
        live_op.err = !(cmd_ok && legal && in_range);
    end

    // Sequencer: IDLE and RESP both accept, WAIT counts down to the response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                default: begin
                    if (accept) begin
                        if (WS != 4'd0) begin
                            state <= ST_WAIT;
                            cnt   <= WS;
                        end else begin
                            state <= ST_RESP;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    if (SCR1_VMEM_WAIT_STATES == 0) begin : g_direct
        assign act_en = accept;
        assign act_op = live_op;
    end else begin : g_held
        op_t pend_op;

        // Hold the accepted operation while the initiator is free to change the bus
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pend_op <= '0;
            end else if (accept) begin
                pend_op <= live_op;
            end
        end

        assign act_en = (state == ST_WAIT) && (cnt == 4'd1);
        assign act_op = pend_op;
    end

    // Commit writes on the edge entering RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (act_en && act_op.wr && !act_op.err) begin
`ifdef SCR1_VMEM_SUBWORD_EN
            if (act_op.full) begin
                mem[act_op.entry] <= act_op.wdata;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (act_op.bmask[b]) begin
                        mem[act_op.entry][act_op.lane][8*b +: 8] <= act_op.wdata[act_op.lane][8*b +: 8];
                    end
                end
            end
`else
            mem[act_op.entry] <= act_op.wdata;
`endif
        end
    end

    // One-cycle response with registered read data, zero outside a good read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_resp  <= SCR1_MEM_RESP_IDLE;
            port_rdata <= '0;
        end else if (act_en) begin
            port_resp  <= act_op.err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            port_rdata <= (!act_op.err && !act_op.wr) ? mem[act_op.entry] : '0;
        end else begin
            port_resp  <= SCR1_MEM_RESP_IDLE;
            port_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_scr1_vmem_responder.sv
// tb/tb_scr1_vmem_responder.sv - randomized self-checking bench for scr1_vmem_responder
`timescale 1ns/1ps
module tb_scr1_vmem_responder;
    import scr1_vmem_pkg::*;

    localparam int          DEPTH = 16;
    localparam int          NI    = 3;
    localparam int          VB    = LANE * 4;
    localparam logic [31:0] BASE  = 32'h00010000;

    typedef struct {
        int          c;
        int          w;
        logic [31:0] a;
        type_vector  d;
    } rq_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ack   [NI];
    logic                 req   [NI];
    type_scr1_mem_cmd_e   cmd   [NI];
    type_scr1_mem_width_e wid   [NI];
    logic [31:0]          addr  [NI];
    type_vector           wdata [NI];
    type_vector           rdata [NI];
    type_scr1_mem_resp_e  resp  [NI];

    logic [7:0] mb [NI][DEPTH*VB];
    int n_cmp;
    int n_err;
    rq_t rq_q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        scr1_vmem_responder #(
            .SCR1_VMEM_DEPTH       (DEPTH),
            .SCR1_VMEM_WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 3 : 2)),
            .SCR1_VMEM_BASE_ADDR   (BASE)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .port_req_ack (ack[g]),
            .port_req     (req[g]),
            .port_cmd     (cmd[g]),
            .port_width   (wid[g]),
            .port_addr    (addr[g]),
            .port_wdata   (wdata[g]),
            .port_rdata   (rdata[g]),
            .port_resp    (resp[g])
        );
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 3 : 2);
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic rq_t mk(input int c, input int w, input logic [31:0] a, input type_vector d);
        rq_t r;
        r.c = c; r.w = w; r.a = a; r.d = d;
        return r;
    endfunction

    function automatic type_vector rnd_vec();
        type_vector v;
        for (int l = 0; l < LANE; l++) v[l] = $urandom;
        return v;
    endfunction

    function automatic rq_t rnd_rq();
        rq_t r;
        int k;
        k = $urandom_range(0, 19);
        r.c = (k < 9) ? int'(SCR1_MEM_CMD_RD) : ((k < 18) ? int'(SCR1_MEM_CMD_WR) : int'(SCR1_MEM_CMD_ERROR));
        k = $urandom_range(0, 9);
        r.w = (k < 6) ? int'(SCR1_MEM_WIDTH_WORD) : ((k < 9) ? $urandom_range(0, 1) : int'(SCR1_MEM_WIDTH_ERROR));
        case ($urandom_range(0, 9))
            0:       r.a = BASE - 32'(4 * $urandom_range(1, 4));
            1:       r.a = BASE + 32'(DEPTH * VB) + 32'($urandom_range(0, 31));
            2, 3:    r.a = BASE + 32'($urandom_range(0, DEPTH * VB - 1));
            default: r.a = BASE + 32'(VB * $urandom_range(0, DEPTH - 1));
        endcase
        r.d = rnd_vec();
        return r;
    endfunction

    // Byte-addressed reference: legality from width/alignment/range, bytes copied by offset
    function automatic void model(input int i, input rq_t r, output bit er, output type_vector rd);
        logic [31:0]         off;
        logic [LANE*32-1:0]  w;
        logic [LANE*32-1:0]  o;
        int                  n;
        int                  e0;
        int                  p;
        off = r.a - BASE;
        n = 0;
        if (r.w == int'(SCR1_MEM_WIDTH_WORD) && (off % VB) == 0) n = VB;
`ifdef SCR1_VMEM_SUBWORD_EN
        else if (r.w == int'(SCR1_MEM_WIDTH_BYTE)) n = 1;
        else if (r.w == int'(SCR1_MEM_WIDTH_HWORD) && (off % 2) == 0) n = 2;
        else if (r.w == int'(SCR1_MEM_WIDTH_WORD) && (off % 4) == 0) n = 4;
`endif
        er = (n == 0) || (off >= DEPTH * VB) ||
             !(r.c == int'(SCR1_MEM_CMD_RD) || r.c == int'(SCR1_MEM_CMD_WR));
        rd = '0;
        if (!er) begin
            w  = r.d;
            p  = int'(off % VB);
            e0 = int'(off) - p;
            if (r.c == int'(SCR1_MEM_CMD_WR)) begin
                for (int k = 0; k < n; k++) mb[i][e0 + p + k] = w[(p + k) * 8 +: 8];
            end else begin
                for (int j = 0; j < VB; j++) o[j * 8 +: 8] = mb[i][e0 + j];
                rd = o;
            end
        end
    endfunction

    task automatic drive(input int i, input rq_t r);
        req[i]   = 1'b1;
        cmd[i]   = type_scr1_mem_cmd_e'(2'(r.c));
        wid[i]   = type_scr1_mem_width_e'(2'(r.w));
        addr[i]  = r.a;
        wdata[i] = r.d;
    endtask

    // Single transaction; bus is scrambled with a held request during the wait states
    task automatic xact(input int i, input rq_t r, input string tag);
        bit         er;
        type_vector ex;
        model(i, r, er, ex);
        @(negedge clk);
        check_eq({tag, ".ack_idle"}, ack[i], 1'b1);
        drive(i, r);
        for (int k = 0; k < ws_of(i); k++) begin
            @(negedge clk);
            drive(i, rnd_rq());
            check_eq({tag, ".wait_resp"}, resp[i], SCR1_MEM_RESP_IDLE);
            check_eq({tag, ".wait_ack"}, ack[i], 1'b0);
            check_eq({tag, ".wait_rdata"}, rdata[i], '0);
        end
        @(negedge clk);
        req[i] = 1'b0;
        check_eq({tag, ".resp"}, resp[i], er ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK);
        check_eq({tag, ".rdata"}, rdata[i], ex);
        check_eq({tag, ".resp_ack"}, ack[i], 1'b1);
    endtask

    // Back-to-back stream on the zero-wait instance: one request per cycle
    task automatic burst(input string tag);
        bit         er_q[$];
        type_vector ex_q[$];
        bit         er;
        type_vector ex;
        rq_t        r;
        int         n;
        n = rq_q.size();
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            check_eq({tag, ".ack"}, ack[0], 1'b1);
            if (k > 0) begin
                er = er_q.pop_front();
                ex = ex_q.pop_front();
                check_eq({tag, ".resp"}, resp[0], er ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK);
                check_eq({tag, ".rdata"}, rdata[0], ex);
            end
            if (k < n) begin
                r = rq_q.pop_front();
                model(0, r, er, ex);
                er_q.push_back(er);
                ex_q.push_back(ex);
                drive(0, r);
            end else begin
                req[0] = 1'b0;
            end
        end
    endtask

    initial begin
        type_vector v;
        rq_t        r0;
        rq_t        r2;
        bit         er;
        type_vector ex;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            req[i] = 1'b0; cmd[i] = SCR1_MEM_CMD_RD; wid[i] = SCR1_MEM_WIDTH_WORD;
            addr[i] = BASE; wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_eq("reset.resp", resp[i], SCR1_MEM_RESP_IDLE);
            check_eq("reset.rdata", rdata[i], '0);
            check_eq("reset.ack", ack[i], 1'b0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < NI; i++)
            for (int e = 0; e < DEPTH; e++)
                xact(i, mk(int'(SCR1_MEM_CMD_WR), int'(SCR1_MEM_WIDTH_WORD), BASE + 32'(e * VB), rnd_vec()), "init");

        v = {LANE{32'h11111111}};
        rq_q.push_back(mk(int'(SCR1_MEM_CMD_WR), int'(SCR1_MEM_WIDTH_WORD), BASE, v));
        rq_q.push_back(mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), BASE, '0));
        burst("wr_rd_pipe");

        xact(1, mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), BASE + 32'(3 * VB), '0), "ws3_rd");

        for (int i = 0; i < NI; i++) begin
            xact(i, mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), BASE + 32'(DEPTH * VB), '0), "past_top");
            xact(i, mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), 32'h0000FFFC, '0), "below_base");
            xact(i, mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), BASE, '0), "entry0");
            xact(i, mk(int'(SCR1_MEM_CMD_ERROR), int'(SCR1_MEM_WIDTH_WORD), BASE + 32'(5 * VB), rnd_vec()), "cmd_err");
            xact(i, mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), BASE + 32'(5 * VB), '0), "entry5");
            xact(i, mk(int'(SCR1_MEM_CMD_WR), int'(SCR1_MEM_WIDTH_BYTE), BASE + 32'd1, rnd_vec()), "byte_01");
            v = '0;
            v[1] = 32'h0000AB00;
            xact(i, mk(int'(SCR1_MEM_CMD_WR), int'(SCR1_MEM_WIDTH_BYTE), BASE + 32'd5, v), "byte_05");
            xact(i, mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), BASE, '0), "entry0_after_byte");
            xact(i, mk(int'(SCR1_MEM_CMD_WR), int'(SCR1_MEM_WIDTH_HWORD), BASE + 32'd3, rnd_vec()), "hword_mis");
        end

        for (int k = 0; k < 200; k++) rq_q.push_back(rnd_rq());
        burst("rand_pipe");
        for (int k = 0; k < 40; k++) begin
            xact(1, rnd_rq(), "rand_ws3");
            xact(2, rnd_rq(), "rand_ws2");
        end

        r0 = mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), BASE + 32'(7 * VB), '0);
        r2 = mk(int'(SCR1_MEM_CMD_WR), int'(SCR1_MEM_WIDTH_WORD), BASE + 32'(7 * VB), rnd_vec());
        model(0, r0, er, ex);
        @(negedge clk);
        drive(0, r0);
        drive(2, r2);
        @(negedge clk);
        req[0] = 1'b0;
        req[2] = 1'b0;
        check_eq("rst.pre_resp", resp[0], SCR1_MEM_RESP_RDY_OK);
        check_eq("rst.pre_wait_ack", ack[2], 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("rst.resp0", resp[0], SCR1_MEM_RESP_IDLE);
        check_eq("rst.rdata0", rdata[0], '0);
        check_eq("rst.ack0", ack[0], 1'b0);
        check_eq("rst.resp2", resp[2], SCR1_MEM_RESP_IDLE);
        check_eq("rst.ack2", ack[2], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        xact(2, mk(int'(SCR1_MEM_CMD_RD), int'(SCR1_MEM_WIDTH_WORD), BASE + 32'(7 * VB), '0), "rst.dropped_wr");
        xact(0, r0, "rst.inst0_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
